// File: rtl/background_scroller.sv
// Background renderer: maps the VGA beam onto a scaled indexed-colour image held
// in an external ROM and pans horizontally between rooms, one step per frame.
module background_scroller #(
   parameter  int IMG_W       = 200,
   parameter  int IMG_H       = 200,
   parameter  int SCREEN_W    = 640,
   parameter  int SCREEN_H    = 480,
   parameter  int NUM_BG      = 4,
   parameter  int IDX_W       = 5,
   parameter  int ADDR_W      = 18,
   parameter  int SCROLL_STEP = 8,
   localparam int BG_W        = (NUM_BG > 1) ? $clog2(NUM_BG) : 1
) (
   input  logic              vga_clk,
   input  logic              reset_n,
   input  logic [9:0]        DrawX,
   input  logic [9:0]        DrawY,
   input  logic              blank,
   input  logic              bg_load,
   input  logic [BG_W-1:0]   bg_sel,
   input  logic              scroll_req,
   input  logic              scroll_dir,
   input  logic [BG_W-1:0]   next_bg,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [IDX_W-1:0]  rom_q,
   output logic [IDX_W-1:0]  pal_index,
   input  logic [3:0]        pal_red,
   input  logic [3:0]        pal_green,
   input  logic [3:0]        pal_blue,
   output logic [3:0]        red,
   output logic [3:0]        green,
   output logic [3:0]        blue,
   output logic              scroll_busy,
   output logic              scroll_done
);

   localparam int          OFF_W    = $clog2(SCREEN_W + 1);
   localparam logic [31:0] SW32     = 32'(SCREEN_W);
   localparam logic [31:0] SH32     = 32'(SCREEN_H);
   localparam logic [31:0] IW32     = 32'(IMG_W);
   localparam logic [31:0] IH32     = 32'(IMG_H);
   localparam logic [31:0] IMG_SZ32 = 32'(IMG_W * IMG_H);
   localparam logic [31:0] STEP32   = 32'(SCROLL_STEP);

   typedef enum logic [1:0] {S_IDLE, S_SCROLL, S_DONE} state_t;

   state_t            state, state_d;
   logic [BG_W-1:0]   cur_bg, cur_bg_d;
   logic [BG_W-1:0]   nxt, nxt_d;
   logic [BG_W-1:0]   pend_bg, pend_bg_d;
   logic              pend_vld, pend_vld_d;
   logic              dir, dir_d;
   logic [OFF_W-1:0]  offset, offset_d;
   logic              frame_tick;
   logic [31:0]       step_sum;

   logic [31:0]       x32, y32, off32, px32, sx32, sy32, img32;
   logic              use_nxt;
   logic [ADDR_W-1:0] addr_d;
   logic              blank_d1, blank_d2;

   // First line of vertical blanking: all pan state changes happen here only.
   assign frame_tick = (DrawX == 10'd0) && (32'(DrawY) == SH32);

   // NOTE: every variable gets a default before the case so no path leaves one
   // unassigned; otherwise synthesis infers a latch to hold the old value.
   always_comb begin
      state_d     = state;
      cur_bg_d    = cur_bg;
      nxt_d       = nxt;
      dir_d       = dir;
      offset_d    = offset;
      pend_bg_d   = pend_bg;
      pend_vld_d  = pend_vld;
      scroll_busy = 1'b0;
      scroll_done = 1'b0;
      step_sum    = 32'(offset) + STEP32;

      unique case (state)
         S_IDLE: begin
            if (scroll_req) begin
               // A scroll request overrides and cancels any queued jump.
               nxt_d      = next_bg;
               dir_d      = scroll_dir;
               pend_vld_d = 1'b0;
               state_d    = S_SCROLL;
            end else begin
               if (frame_tick && pend_vld) begin
                  cur_bg_d   = pend_bg;
                  pend_vld_d = 1'b0;
               end
               if (bg_load) begin
                  pend_bg_d  = bg_sel;
                  pend_vld_d = 1'b1;
               end
            end
         end
         S_SCROLL: begin
            scroll_busy = 1'b1;
            if (frame_tick) begin
               if (step_sum >= SW32) begin
                  cur_bg_d = nxt;
                  offset_d = '0;
                  state_d  = S_DONE;
               end else begin
                  offset_d = OFF_W'(step_sum);
               end
            end
         end
         S_DONE: begin
            scroll_done = 1'b1;
            state_d     = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Beam-to-image mapping; constant division yields the exact floor.
   always_comb begin
      x32     = 32'(DrawX);
      y32     = 32'(DrawY);
      off32   = 32'(offset);
      use_nxt = 1'b0;
      px32    = '0;
      if (!dir) begin
         if (x32 + off32 < SW32) begin
            px32 = x32 + off32;
         end else begin
            use_nxt = 1'b1;
            px32    = x32 + off32 - SW32;
         end
      end else begin
         if (x32 >= off32) begin
            px32 = x32 - off32;
         end else begin
            use_nxt = 1'b1;
            px32    = x32 + SW32 - off32;
         end
      end
      sx32   = (px32 * IW32) / SW32;
      sy32   = (y32 * IH32) / SH32;
      img32  = use_nxt ? 32'(nxt) : 32'(cur_bg);
      addr_d = ADDR_W'(img32 * IMG_SZ32 + sy32 * IW32 + sx32);
   end

   assign pal_index = rom_q;

   // NOTE: clocked state uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= S_IDLE;
         cur_bg   <= '0;
         nxt      <= '0;
         dir      <= 1'b0;
         offset   <= '0;
         pend_bg  <= '0;
         pend_vld <= 1'b0;
         rom_addr <= '0;
         blank_d1 <= 1'b0;
         blank_d2 <= 1'b0;
         red      <= '0;
         green    <= '0;
         blue     <= '0;
      end else begin
         state    <= state_d;
         cur_bg   <= cur_bg_d;
         nxt      <= nxt_d;
         dir      <= dir_d;
         offset   <= offset_d;
         pend_bg  <= pend_bg_d;
         pend_vld <= pend_vld_d;
         rom_addr <= addr_d;
         blank_d1 <= blank;
         blank_d2 <= blank_d1;
         // Third blank stage is the colour register itself.
         red      <= blank_d2 ? pal_red   : 4'h0;
         green    <= blank_d2 ? pal_green : 4'h0;
         blue     <= blank_d2 ? pal_blue  : 4'h0;
      end
   end

endmodule

// File: tb/tb_background_scroller.sv
// Randomised scoreboard bench for background_scroller: a frame-level reference
// model predicts addresses, colours and handshake flags per pixel issued.
module tb_background_scroller;

   localparam int IMG_W = 200, IMG_H = 200, SW = 640, SH = 480;
   localparam int NUM_BG = 4, IDX_W = 5, ADDR_W = 18, STEP = 8;

   logic              vga_clk = 1'b0;
   logic              reset_n;
   logic [9:0]        DrawX, DrawY;
   logic              blank, bg_load, scroll_req, scroll_dir;
   logic [1:0]        bg_sel, next_bg;
   logic [ADDR_W-1:0] rom_addr;
   logic [IDX_W-1:0]  rom_q = '0;
   logic [IDX_W-1:0]  pal_index;
   logic [3:0]        pal_red, pal_green, pal_blue, red, green, blue;
   logic              scroll_busy, scroll_done;

   always #5 vga_clk = ~vga_clk;

   background_scroller #(
      .IMG_W(IMG_W), .IMG_H(IMG_H), .SCREEN_W(SW), .SCREEN_H(SH), .NUM_BG(NUM_BG),
      .IDX_W(IDX_W), .ADDR_W(ADDR_W), .SCROLL_STEP(STEP)
   ) dut (
      .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
      .bg_load(bg_load), .bg_sel(bg_sel), .scroll_req(scroll_req), .scroll_dir(scroll_dir),
      .next_bg(next_bg), .rom_addr(rom_addr), .rom_q(rom_q), .pal_index(pal_index),
      .pal_red(pal_red), .pal_green(pal_green), .pal_blue(pal_blue),
      .red(red), .green(green), .blue(blue),
      .scroll_busy(scroll_busy), .scroll_done(scroll_done)
   );

   // External ROM contents and palette, both arbitrary but deterministic.
   function automatic logic [4:0] rom_fn(input logic [17:0] a);
      return a[4:0] ^ a[9:5] ^ a[14:10] ^ {2'b00, a[17:15]};
   endfunction

   function automatic logic [11:0] pal_rgb(input logic [4:0] i);
      return {i[3:0], i[4:1], i[3:0] ^ 4'hA};
   endfunction

   always @(posedge vga_clk) rom_q <= rom_fn(rom_addr);
   assign {pal_red, pal_green, pal_blue} = pal_rgb(pal_index);

   int checks = 0, errors = 0, cyc = 0;
   always @(posedge vga_clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   typedef struct {int due; bit care; logic [17:0] addr; bit busy; bit done;} addr_item_t;
   typedef struct {int due; logic [11:0] rgb;} rgb_item_t;
   addr_item_t aq[$];
   rgb_item_t  cq[$];

   // Reference model: scroll progress kept as a count of frames since acceptance.
   int m_cur, m_nxt, m_dir, m_frames, m_pend;
   bit m_scrolling, m_done;

   task automatic model_reset();
      m_cur = 0; m_nxt = 0; m_dir = 0; m_frames = 0; m_pend = -1;
      m_scrolling = 0; m_done = 0;
   endtask

   function automatic int ref_addr(input int x, input int y);
      int off, img, px;
      off = m_scrolling ? m_frames * STEP : 0;
      if (m_dir == 0) begin
         if (x + off < SW) begin img = m_cur; px = x + off; end
         else begin img = m_nxt; px = x + off - SW; end
      end else begin
         if (x >= off) begin img = m_cur; px = x - off; end
         else begin img = m_nxt; px = x + SW - off; end
      end
      return img * IMG_W * IMG_H + (y * IMG_H / SH) * IMG_W + (px * IMG_W / SW);
   endfunction

   task automatic drive(input int x, input int y, input bit bl, input bit ld, input int sel,
                        input bit req, input bit sdir, input int nb);
      bit care, tick;
      int exp;
      @(posedge vga_clk); #1;
      DrawX = 10'(x); DrawY = 10'(y); blank = bl; bg_load = ld; bg_sel = 2'(sel);
      scroll_req = req; scroll_dir = sdir; next_bg = 2'(nb);
      care = (x < SW) && (y < SH);
      tick = (x == 0) && (y == SH);
      exp  = care ? ref_addr(x, y) : 0;
      cq.push_back('{cyc + 3, bl ? pal_rgb(rom_fn(18'(exp))) : 12'h000});
      if (m_done) begin
         m_done = 0;
      end else if (m_scrolling) begin
         if (tick) begin
            m_frames++;
            if (m_frames * STEP >= SW) begin
               m_cur = m_nxt; m_scrolling = 0; m_done = 1;
            end
         end
      end else if (req) begin
         m_nxt = nb; m_dir = sdir; m_pend = -1; m_scrolling = 1; m_frames = 0;
      end else begin
         if (tick && m_pend >= 0) begin m_cur = m_pend; m_pend = -1; end
         if (ld) m_pend = sel;
      end
      aq.push_back('{cyc + 1, care, 18'(exp), m_scrolling, m_done});
   endtask

   task automatic pix(input int x, input int y, input bit bl);
      drive(x, y, bl, 0, 0, 0, 0, 0);
   endtask

   task automatic rnd_pix();
      pix($urandom_range(0, SW - 1), $urandom_range(0, SH - 1), $urandom_range(0, 3) != 0);
   endtask

   task automatic tick_frame();
      pix(0, SH, 0);
   endtask

   task automatic drain();
      int t = 0;
      repeat (4) pix(700, 10, 0);
      while ((aq.size() != 0 || cq.size() != 0) && t < 20) begin
         @(posedge vga_clk); t++;
      end
      check("scoreboard_drained", aq.size() + cq.size(), 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_rom_addr"}, rom_addr, 0);
      check({tag, "_rgb"}, {red, green, blue}, 0);
      check({tag, "_busy"}, scroll_busy, 0);
      check({tag, "_done"}, scroll_done, 0);
   endtask

   // Monitor: pops whatever the DUT should be presenting this cycle.
   addr_item_t a_it;
   rgb_item_t  c_it;
   always @(negedge vga_clk) begin
      while (aq.size() != 0 && aq[0].due <= cyc) begin
         a_it = aq.pop_front();
         if (a_it.care) check("rom_addr", rom_addr, a_it.addr);
         check("scroll_busy", scroll_busy, a_it.busy);
         check("scroll_done", scroll_done, a_it.done);
      end
      while (cq.size() != 0 && cq[0].due <= cyc) begin
         c_it = cq.pop_front();
         check("rgb", {red, green, blue}, c_it.rgb);
      end
   end

   initial begin
      reset_n = 1'b0; DrawX = '0; DrawY = '0; blank = 1'b0; bg_load = 1'b0; bg_sel = '0;
      scroll_req = 1'b0; scroll_dir = 1'b0; next_bg = '0;
      model_reset();
      #3;
      check_reset_outputs("reset");
      repeat (2) @(posedge vga_clk);
      #1 reset_n = 1'b1;

      // Plain mapping on background 0.
      pix(320, 240, 1);
      repeat (15) rnd_pix();

      // Jump to background 2: base changes only after the next frame tick.
      drive(5, $urandom_range(0, SH - 1), 1, 1, 2, 0, 0, 0);
      repeat (5) rnd_pix();
      tick_frame();
      pix(0, 0, 1);
      repeat (5) rnd_pix();
      repeat (4) pix($urandom_range(0, SW - 1), $urandom_range(0, SH - 1), 0);
      drive(10, 10, 1, 1, 0, 0, 0, 0);
      tick_frame();

      // Scroll right into background 1, with ignored requests mid-scroll.
      drive(100, 100, 1, 0, 0, 1, 0, 1);
      repeat (10) begin tick_frame(); rnd_pix(); end
      pix(600, 0, 1);
      pix(0, 0, 1);
      drive(50, 50, 1, 1, 3, 1, 1, 2);
      repeat (70) begin tick_frame(); rnd_pix(); end
      rnd_pix();
      pix(0, 0, 1);

      // Pending load, then scroll_req + bg_load together: scroll left to 3.
      drive(5, 5, 1, 1, 2, 0, 0, 0);
      drive(7, 7, 1, 1, 1, 1, 1, 3);
      repeat (10) begin tick_frame(); rnd_pix(); end
      pix(40, 0, 1);
      repeat (70) begin tick_frame(); rnd_pix(); end
      repeat (2) rnd_pix();
      tick_frame();
      pix(0, 0, 1);

      // Request on a tick cycle, then reset once the pan reaches 320.
      drive(0, SH, 0, 0, 0, 1, $urandom_range(0, 1), $urandom_range(0, NUM_BG - 1));
      repeat (5) rnd_pix();
      tick_frame();
      repeat (5) rnd_pix();
      repeat (39) begin tick_frame(); rnd_pix(); end
      drain();
      @(posedge vga_clk); #1 reset_n = 1'b0;
      #1 check_reset_outputs("midscroll_reset");
      @(posedge vga_clk); #1 reset_n = 1'b1;
      model_reset();
      pix(0, 0, 1);
      repeat (10) rnd_pix();
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
